ps2_host_tx: RTL and testbench

- PS/2 host-to-device transmitter. Sends one command byte (for example 0xED set-LEDs or 0xFF reset) to the keyboard or mouse over the bidirectional open-drain PS/2 clock and data lines.
- Line inputs arrive already synchronised and filtered by the PS/2 receive-side input filters.
- Outputs are active-high open-drain enables; the pad drives the line low while an enable is 1.
- Sits beside the PS/2 receiver and shares the same pads.

---
 rtl/ps2_host_tx.sv | 141 ++++++++++++++
 tb/tb_ps2_host_tx.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues a request-to-send, then shifts
// one command byte out on device-generated clock falls and collects the device ack.
module ps2_host_tx #(
   parameter int unsigned INHIBIT_CYCLES = 5000,
   parameter int unsigned TIMEOUT_CYCLES = 1500000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       tx_valid,
   input  logic [7:0] tx_data,
   output logic       tx_ready,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe,
   output logic       busy,
   output logic       done,
   output logic       error,
   output logic [1:0] err_code
);

   localparam int unsigned MaxCycles =
      (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
   localparam int unsigned CntW = $clog2(MaxCycles + 1);
   localparam logic [CntW-1:0] InhibitLast = CntW'(INHIBIT_CYCLES - 1);
   localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      StIdle,
      StInhibit,
      StReq,
      StSend,
      StAck,
      StRelease
   } state_t;

   state_t          state;
   logic            clk_prev;
   logic [10:0]     frame;     // {stop, parity, data[7:0], start}
   logic [3:0]      bit_idx;
   logic [3:0]      next_idx;
   logic [CntW-1:0] cnt;
   logic            nack;
   logic            fall;
   logic            timed;
   logic            accept;

   assign fall     = clk_prev & ~ps2_clk_in;
   assign timed    = (state == StSend) || (state == StAck) || (state == StRelease);
   // Held low during the done/error pulse so a waiting request starts one cycle later.
   assign tx_ready = (state == StIdle) & ~done & ~error;
   assign busy     = (state != StIdle);
   assign accept   = tx_valid & tx_ready;
   assign next_idx = bit_idx + 4'd1;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= StIdle;
         clk_prev    <= 1'b1;
         frame       <= '0;
         bit_idx     <= '0;
         cnt         <= '0;
         nack        <= 1'b0;
         ps2_clk_oe  <= 1'b0;
         ps2_data_oe <= 1'b0;
         done        <= 1'b0;
         error       <= 1'b0;
         err_code    <= 2'b00;
      end else begin
         clk_prev <= ps2_clk_in;
         done     <= 1'b0;
         error    <= 1'b0;
         if (timed) begin
            cnt <= fall ? '0 : cnt + 1'b1;
         end
         // Device went silent: abort wins over a fall arriving on the same edge.
         if (timed && (cnt == TimeoutLast)) begin
            state       <= StIdle;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            error       <= 1'b1;
            err_code    <= 2'b01;
         end else begin
            unique case (state)
               StIdle: begin
                  if (accept) begin
                     state      <= StInhibit;
                     frame      <= {1'b1, ~^tx_data, tx_data, 1'b0};
                     cnt        <= '0;
                     bit_idx    <= '0;
                     nack       <= 1'b0;
                     ps2_clk_oe <= 1'b1;
                  end
               end
               StInhibit: begin
                  if (cnt == InhibitLast) begin
                     state       <= StReq;
                     ps2_data_oe <= 1'b1;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               StReq: begin
                  state       <= StSend;
                  ps2_clk_oe  <= 1'b0;
                  ps2_data_oe <= ~frame[0];
                  bit_idx     <= '0;
                  cnt         <= '0;
               end
               StSend: begin
                  if (fall) begin
                     bit_idx     <= next_idx;
                     ps2_data_oe <= ~frame[next_idx];
                     if (bit_idx == 4'd9) begin
                        state <= StAck;
                     end
                  end
               end
               StAck: begin
                  if (fall) begin
                     nack  <= ps2_data_in;
                     state <= StRelease;
                  end
               end
               StRelease: begin
                  if (ps2_clk_in && ps2_data_in) begin
                     state <= StIdle;
                     done  <= ~nack;
                     error <= nack;
                     if (nack) begin
                        err_code <= 2'b10;
                     end
                  end
               end
               default: state <= StIdle;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device on wired-AND lines, a pulse scoreboard
// and a table of command bytes, plus timeout, reset-abort and held-request sequences.
module tb_ps2_host_tx;

   localparam int ModeAck   = 0;
   localparam int ModeNack  = 1;
   localparam int ModeNoClk = 2;
   localparam int ModeAbort = 3;

   typedef struct packed {
      logic       done;
      logic       error;
      logic [1:0] code;
   } exp_t;

   typedef struct {
      logic [7:0] data;
      logic       exp_par;
      int         mode;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       tx_valid;
   logic [7:0] tx_data;
   logic       tx_ready;
   logic       ps2_clk_in;
   logic       ps2_data_in;
   logic       ps2_clk_oe;
   logic       ps2_data_oe;
   logic       busy;
   logic       done;
   logic       error;
   logic [1:0] err_code;

   logic dev_clk  = 1'b1;
   logic dev_data = 1'b1;

   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t sb_q[$];
   bit   ready_next = 1'b0;

   always #5 clk = ~clk;

   assign ps2_clk_in  = ~ps2_clk_oe & dev_clk;
   assign ps2_data_in = ~ps2_data_oe & dev_data;

   ps2_host_tx #(
      .INHIBIT_CYCLES(8),
      .TIMEOUT_CYCLES(64)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .tx_valid   (tx_valid),
      .tx_data    (tx_data),
      .tx_ready   (tx_ready),
      .ps2_clk_in (ps2_clk_in),
      .ps2_data_in(ps2_data_in),
      .ps2_clk_oe (ps2_clk_oe),
      .ps2_data_oe(ps2_data_oe),
      .busy       (busy),
      .done       (done),
      .error      (error),
      .err_code   (err_code)
   );

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Pops one expectation per done/error pulse.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (ready_next) begin
            check("ready_after_pulse", tx_ready, 1);
            ready_next = 1'b0;
         end
         if (done || error) begin
            check("ready_low_in_pulse", tx_ready, 0);
            if (sb_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_pulse: got done=%b error=%b, expected none", done, error);
            end else begin
               e = sb_q.pop_front();
               check("done_pulse", done, e.done);
               check("error_pulse", error, e.error);
               if (e.error) check("err_code", err_code, e.code);
               ready_next = 1'b1;
            end
         end
      end
   end

   task automatic run_xfer(input logic [7:0] d, input logic exp_par, input int mode,
                           input bit hold, input logic [7:0] d_next);
      int          n;
      int          last;
      logic [10:0] frame;
      logic [10:0] exp_frame;
      exp_frame = {1'b1, exp_par, d, 1'b0};
      frame     = '0;
      tx_data   = d;
      tx_valid  = 1'b1;
      n = 0;
      while (!tx_ready && n < 200) begin
         tick();
         n++;
      end
      check("accept_ready", tx_ready, 1);
      if (mode == ModeAck) sb_q.push_back('{1'b1, 1'b0, 2'b00});
      else if (mode == ModeNack) sb_q.push_back('{1'b0, 1'b1, 2'b10});
      else if (mode == ModeNoClk) sb_q.push_back('{1'b0, 1'b1, 2'b01});
      tick();
      if (hold) tx_data = d_next;
      else tx_valid = 1'b0;
      check("busy_after_accept", busy, 1);
      n = 0;
      while (ps2_clk_oe && !ps2_data_oe && n < 100) begin
         tick();
         n++;
      end
      check("inhibit_len", n, 8);
      n = 0;
      while (ps2_clk_oe && ps2_data_oe && n < 100) begin
         tick();
         n++;
      end
      check("req_len", n, 1);
      check("send_entry_oe", {ps2_clk_oe, ps2_data_oe}, 2'b01);

      if (mode == ModeNoClk) begin
         n = 0;
         while (!error && n < 200) begin
            tick();
            n++;
         end
         check("timeout_cycles", n, 64);
         check("timeout_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
         tick();
         check("timeout_ready", tx_ready, 1);
         return;
      end

      repeat (3) tick();
      frame[0] = ps2_data_in;
      last = (mode == ModeAbort) ? 5 : 11;
      for (int k = 1; k <= last; k++) begin
         if (k == 11 && mode == ModeAck) dev_data = 1'b0;
         dev_clk = 1'b0;
         repeat (10) tick();
         if (k <= 10) frame[k] = ps2_data_in;
         dev_clk = 1'b1;
         if (k < last) repeat (10) tick();
      end
      if (mode == ModeAbort) begin
         repeat (5) tick();
      end else begin
         if (mode == ModeAck) begin
            repeat (5) tick();
            dev_data = 1'b1;
         end
         check("frame", frame, exp_frame);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no end of test, expected $finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t vecs[4];
      vecs[0] = '{8'hED, 1'b1, ModeAck};
      vecs[1] = '{8'h01, 1'b0, ModeAck};
      vecs[2] = '{8'h00, 1'b1, ModeAck};
      vecs[3] = '{8'hA5, 1'b1, ModeNack};

      reset_n  = 1'b0;
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      repeat (3) tick();
      check("rst_clk_oe", ps2_clk_oe, 0);
      check("rst_data_oe", ps2_data_oe, 0);
      check("rst_done_error", {done, error}, 2'b00);
      check("rst_err_code", err_code, 2'b00);
      check("rst_busy", busy, 0);
      check("rst_tx_ready", tx_ready, 1);
      reset_n = 1'b1;
      tick();

      for (int i = 0; i < 4; i++) begin
         run_xfer(vecs[i].data, vecs[i].exp_par, vecs[i].mode, 1'b0, 8'h00);
      end
      repeat (4) tick();
      check("nack_code_hold", err_code, 2'b10);

      run_xfer(8'h55, 1'b1, ModeNoClk, 1'b0, 8'h00);
      repeat (4) tick();
      check("timeout_code_hold", err_code, 2'b01);

      // Abort between falls #5 and #6 while data bit 4 (a zero) is being driven low.
      run_xfer(8'h00, 1'b1, ModeAbort, 1'b0, 8'h00);
      check("pre_reset_data_oe", ps2_data_oe, 1);
      reset_n = 1'b0;
      #1;
      check("async_rst_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
      check("async_rst_busy", busy, 0);
      repeat (2) tick();
      reset_n = 1'b1;
      tick();
      check("post_rst_ready", tx_ready, 1);
      check("post_rst_err_code", err_code, 2'b00);
      run_xfer(8'hFF, 1'b1, ModeAck, 1'b0, 8'h00);

      // Request held high with a new byte across the whole first transfer.
      run_xfer(8'h3C, 1'b1, ModeAck, 1'b1, 8'hC3);
      run_xfer(8'hC3, 1'b1, ModeAck, 1'b0, 8'h00);

      repeat (10) tick();
      check("scoreboard_empty", sb_q.size(), 0);
      check("final_idle", {busy, tx_ready}, 2'b01);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
